escalonador_processos: RTL and testbench

Round-robin process scheduler for the multiprogrammed processor. It owns the per-process saved-PC table and a quantum counter, and decides when to switch context. It drives `processo_atual`, which the branch-correction stage uses to relocate branch targets into the active process's code block. It sits directly upstream of that stage and beside the PC register, which it freezes and reloads during a switch.

---
 rtl/escalonador_processos.sv | 153 +++++++++++++++
 tb/tb_escalonador_processos.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/escalonador_processos.sv
// Round-robin process scheduler: per-slot saved PC table, quantum counter
// and the freeze/restore sequence that hands the PC register a new process.
module escalonador_processos #(
  parameter int unsigned NUM_PROC = 2,
  parameter int unsigned PROC_W   = 1,
  parameter logic [31:0] QUANTUM  = 32'd16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_concluida,
  input  logic [31:0]       pc_atual,
  input  logic              habilita_escalonador,
  input  logic              processo_fim,
  input  logic              criar_processo,
  input  logic [PROC_W-1:0] id_novo,
  output logic [PROC_W-1:0] processo_atual,
  output logic [31:0]       pc_restaurado,
  output logic              troca_contexto,
  output logic              congela_pc,
  output logic              parado
);

  typedef enum logic [2:0] {
    EXECUTANDO,
    SALVANDO,
    SELECIONANDO,
    RESTAURANDO,
    OCIOSO
  } estado_t;

  estado_t             estado;
  logic [NUM_PROC-1:0] pronto;
  logic [31:0]         tabela_pc [NUM_PROC];
  logic [31:0]         contador_quantum;
  logic                salvar_pc;
  logic [PROC_W-1:0]   escolhido;

  logic                conta;
  logic                expira;
  logic                criar_ok;
  logic                achou;
  logic [PROC_W-1:0]   candidato;

  function automatic logic [PROC_W-1:0] vizinho(
    input logic [PROC_W-1:0] base,
    input int unsigned       passo
  );
    int unsigned s;
    s = (32'(base) + passo) % NUM_PROC;
    return PROC_W'(s);
  endfunction

  assign conta    = instr_concluida && habilita_escalonador;
  assign expira   = conta && (contador_quantum == QUANTUM - 32'd1);
  assign criar_ok = criar_processo
                 && (32'(id_novo) < NUM_PROC)
                 && !pronto[id_novo];

  // Scan from the largest offset down so the nearest ready slot wins;
  // offset NUM_PROC is the current slot, which therefore comes last.
  always_comb begin
    achou     = 1'b0;
    candidato = '0;
    for (int k = int'(NUM_PROC); k >= 1; k--) begin
      if (pronto[vizinho(processo_atual, k)]) begin
        achou     = 1'b1;
        candidato = vizinho(processo_atual, k);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado           <= EXECUTANDO;
      pronto           <= NUM_PROC'(1);
      contador_quantum <= '0;
      salvar_pc        <= 1'b0;
      escolhido        <= '0;
      processo_atual   <= '0;
      pc_restaurado    <= '0;
      troca_contexto   <= 1'b0;
      congela_pc       <= 1'b0;
      parado           <= 1'b0;
      for (int i = 0; i < int'(NUM_PROC); i++) begin
        tabela_pc[i] <= '0;
      end
    end else begin
      troca_contexto <= 1'b0;

      if (criar_ok) begin
        pronto[id_novo]    <= 1'b1;
        tabela_pc[id_novo] <= '0;
      end

      unique case (estado)
        EXECUTANDO: begin
          if (conta) begin
            contador_quantum <= contador_quantum + 32'd1;
          end
          // A halt overrides a same-cycle creation on the running slot.
          if (processo_fim) begin
            pronto[processo_atual] <= 1'b0;
            salvar_pc              <= 1'b0;
            estado                 <= SALVANDO;
            congela_pc             <= 1'b1;
          end else if (expira) begin
            salvar_pc  <= 1'b1;
            estado     <= SALVANDO;
            congela_pc <= 1'b1;
          end
        end

        SALVANDO: begin
          if (salvar_pc) begin
            tabela_pc[processo_atual] <= pc_atual;
          end
          estado <= SELECIONANDO;
        end

        SELECIONANDO: begin
          if (achou) begin
            escolhido <= candidato;
            estado    <= RESTAURANDO;
          end else begin
            estado <= OCIOSO;
            parado <= 1'b1;
          end
        end

        RESTAURANDO: begin
          processo_atual   <= escolhido;
          pc_restaurado    <= tabela_pc[escolhido];
          contador_quantum <= '0;
          troca_contexto   <= 1'b1;
          congela_pc       <= 1'b0;
          estado           <= EXECUTANDO;
        end

        OCIOSO: begin
          if (|pronto) begin
            parado <= 1'b0;
            estado <= SELECIONANDO;
          end
        end

        default: begin
          estado <= EXECUTANDO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_escalonador_processos.sv
// Bench for escalonador_processos: directed scenarios plus random traffic
// checked against a slot-table / rotation model of the scheduler.
module tb_escalonador_processos;

  localparam int NP = 3;
  localparam int Q  = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        instr_concluida = 1'b0;
  logic [31:0] pc_atual = '0;
  logic        habilita_escalonador = 1'b1;
  logic        processo_fim = 1'b0;
  logic        criar_processo = 1'b0;
  logic [1:0]  id_novo = '0;
  logic [1:0]  processo_atual;
  logic [31:0] pc_restaurado;
  logic        troca_contexto;
  logic        congela_pc;
  logic        parado;

  escalonador_processos #(
    .NUM_PROC(NP),
    .PROC_W  (2),
    .QUANTUM (32'd16)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .instr_concluida     (instr_concluida),
    .pc_atual            (pc_atual),
    .habilita_escalonador(habilita_escalonador),
    .processo_fim        (processo_fim),
    .criar_processo      (criar_processo),
    .id_novo             (id_novo),
    .processo_atual      (processo_atual),
    .pc_restaurado       (pc_restaurado),
    .troca_contexto      (troca_contexto),
    .congela_pc          (congela_pc),
    .parado              (parado)
  );

  always #5 clock = ~clock;

  int n_testes = 0;
  int n_falhas = 0;

  bit          m_ready [NP];
  logic [31:0] m_pc    [NP];
  int          m_cur;
  int          m_cnt;

  function automatic int proximo();
    for (int k = 1; k <= NP; k++) begin
      int s;
      s = (m_cur + k) % NP;
      if (m_ready[s]) return s;
    end
    return -1;
  endfunction

  task automatic avanca(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic faz_reset();
    reset = 1'b1;
    instr_concluida = 1'b0;
    processo_fim = 1'b0;
    criar_processo = 1'b0;
    habilita_escalonador = 1'b1;
    avanca(1);
    reset = 1'b0;
    for (int i = 0; i < NP; i++) begin
      m_ready[i] = (i == 0);
      m_pc[i] = '0;
    end
    m_cur = 0;
    m_cnt = 0;
  endtask

  // One running cycle; the model decides whether this edge starts a switch.
  task automatic executa(input bit instr, input bit hab,
                         input logic [31:0] pc, input bit fim,
                         input bit cria, input logic [1:0] id,
                         output bit disparo);
    bit salva;
    instr_concluida = instr;
    habilita_escalonador = hab;
    pc_atual = pc;
    processo_fim = fim;
    criar_processo = cria;
    id_novo = id;
    disparo = fim || (instr && hab && m_cnt == Q - 1);
    salva = disparo && !fim;
    if (cria && int'(id) < NP && !m_ready[id]) begin
      m_ready[id] = 1'b1;
      m_pc[id] = '0;
    end
    if (fim) m_ready[m_cur] = 1'b0;
    if (instr && hab) m_cnt++;
    if (salva) m_pc[m_cur] = pc;
    avanca(1);
    instr_concluida = 1'b0;
    processo_fim = 1'b0;
    criar_processo = 1'b0;
  endtask

  // Returns edges until the pulse (-1 on timeout) and whether the
  // freeze held with processo_atual stable until then.
  task automatic aguarda_pulso(input int limite, output int lat,
                               output bit estavel);
    logic [1:0] p0;
    p0 = processo_atual;
    lat = -1;
    estavel = 1'b1;
    for (int i = 1; i <= limite; i++) begin
      @(posedge clock);
      #1;
      if (troca_contexto === 1'b1) begin
        lat = i;
        break;
      end
      if (congela_pc !== 1'b1 || processo_atual !== p0) estavel = 1'b0;
    end
  endtask

  task automatic test_reset();
    faz_reset();
    n_testes++;
    if (processo_atual !== 2'd0) begin
      n_falhas++;
      $display("FAIL reset_proc: got %0d want 0", processo_atual);
    end
    n_testes++;
    if (pc_restaurado !== 32'd0) begin
      n_falhas++;
      $display("FAIL reset_pc: got %0d want 0", pc_restaurado);
    end
    n_testes++;
    if ({troca_contexto, congela_pc, parado} !== 3'b000) begin
      n_falhas++;
      $display("FAIL reset_flags: got %b want 000",
               {troca_contexto, congela_pc, parado});
    end
  endtask

  task automatic troca_por_quantum(input string nome, input logic [31:0] pc,
                                   input int want_proc,
                                   input logic [31:0] want_pc);
    bit d;
    int lat;
    bit est;
    int nx;
    for (int i = 1; i <= Q; i++) begin
      executa(1'b1, 1'b1, pc, 1'b0, 1'b0, 2'd0, d);
      n_testes++;
      if (congela_pc !== (i == Q)) begin
        n_falhas++;
        $display("FAIL %s_freeze@%0d: got %b want %b", nome, i,
                 congela_pc, (i == Q));
      end
    end
    nx = proximo();
    aguarda_pulso(8, lat, est);
    n_testes++;
    if (lat !== 3 || !est) begin
      n_falhas++;
      $display("FAIL %s_latency: got %0d stable=%b want 3 stable=1",
               nome, lat, est);
    end
    n_testes++;
    if (int'(processo_atual) !== want_proc || nx !== want_proc) begin
      n_falhas++;
      $display("FAIL %s_proc: got %0d want %0d", nome, processo_atual,
               want_proc);
    end
    n_testes++;
    if (pc_restaurado !== want_pc || congela_pc !== 1'b0) begin
      n_falhas++;
      $display("FAIL %s_pc: got %0d freeze=%b want %0d freeze=0", nome,
               pc_restaurado, congela_pc, want_pc);
    end
    m_cur = want_proc;
    m_cnt = 0;
  endtask

  task automatic test_expiracao();
    bit d;
    executa(1'b0, 1'b1, 32'd40, 1'b0, 1'b1, 2'd1, d);
    troca_por_quantum("expiry", 32'd40, 1, 32'd0);
  endtask

  task automatic test_ida_volta();
    troca_por_quantum("roundtrip", 32'd12, 0, 32'd40);
  endtask

  task automatic espera_ocioso(input string nome);
    avanca(2);
    n_testes++;
    if (parado !== 1'b1 || congela_pc !== 1'b1) begin
      n_falhas++;
      $display("FAIL %s_idle: got parado=%b freeze=%b want 1 1", nome,
               parado, congela_pc);
    end
  endtask

  task automatic test_fim();
    bit d;
    int lat;
    bit est;
    troca_por_quantum("tofim", 32'd7, 1, 32'd12);
    executa(1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 2'd0, d);
    aguarda_pulso(8, lat, est);
    n_testes++;
    if (lat !== 3 || processo_atual !== 2'd0 || pc_restaurado !== 32'd7) begin
      n_falhas++;
      $display("FAIL halt1: got lat=%0d proc=%0d pc=%0d want 3 0 7", lat,
               processo_atual, pc_restaurado);
    end
    m_cur = 0;
    m_cnt = 0;
    executa(1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 2'd0, d);
    espera_ocioso("halt0");
    executa(1'b0, 1'b1, 32'd0, 1'b0, 1'b1, 2'd3, d);
    aguarda_pulso(4, lat, est);
    n_testes++;
    if (lat !== -1 || parado !== 1'b1) begin
      n_falhas++;
      $display("FAIL badid: got lat=%0d parado=%b want -1 1", lat, parado);
    end
    executa(1'b0, 1'b1, 32'd0, 1'b0, 1'b1, 2'd1, d);
    aguarda_pulso(8, lat, est);
    n_testes++;
    if (lat !== 3 || processo_atual !== 2'd1 || pc_restaurado !== 32'd0
        || parado !== 1'b0) begin
      n_falhas++;
      $display("FAIL wake: got lat=%0d proc=%0d pc=%0d parado=%b want 3 1 0 0",
               lat, processo_atual, pc_restaurado, parado);
    end
    m_cur = 1;
    m_cnt = 0;
    executa(1'b1, 1'b1, 32'd5, 1'b1, 1'b1, 2'd1, d);
    espera_ocioso("fimcria");
    executa(1'b0, 1'b1, 32'd0, 1'b0, 1'b1, 2'd0, d);
    aguarda_pulso(8, lat, est);
    n_testes++;
    if (lat !== 3 || processo_atual !== 2'd0 || pc_restaurado !== 32'd0) begin
      n_falhas++;
      $display("FAIL wake0: got lat=%0d proc=%0d pc=%0d want 3 0 0", lat,
               processo_atual, pc_restaurado);
    end
    m_cur = 0;
    m_cnt = 0;
  endtask

  task automatic test_sem_preempcao();
    bit d;
    int lat;
    bit est;
    int nx;
    executa(1'b0, 1'b1, 32'd0, 1'b0, 1'b1, 2'd2, d);
    for (int i = 0; i < 5; i++) executa(1'b1, 1'b1, 32'd3, 1'b0, 1'b0, 2'd0, d);
    for (int i = 0; i < 40; i++) begin
      executa(1'b1, 1'b0, 32'd3, 1'b0, 1'b0, 2'd0, d);
      n_testes++;
      if (congela_pc !== 1'b0 || troca_contexto !== 1'b0) begin
        n_falhas++;
        $display("FAIL frozen_q@%0d: got freeze=%b pulse=%b want 0 0", i,
                 congela_pc, troca_contexto);
      end
    end
    for (int i = 1; i <= Q - 5; i++) begin
      executa(1'b1, 1'b1, 32'd77, 1'b0, 1'b0, 2'd0, d);
      n_testes++;
      if (congela_pc !== (i == Q - 5)) begin
        n_falhas++;
        $display("FAIL resume@%0d: got %b want %b", i, congela_pc,
                 (i == Q - 5));
      end
    end
    nx = proximo();
    aguarda_pulso(8, lat, est);
    n_testes++;
    if (lat !== 3 || processo_atual !== 2'd2 || nx !== 2
        || pc_restaurado !== 32'd0) begin
      n_falhas++;
      $display("FAIL resume_switch: got lat=%0d proc=%0d pc=%0d want 3 2 0",
               lat, processo_atual, pc_restaurado);
    end
    m_cur = 2;
    m_cnt = 0;
  endtask

  task automatic test_processo_unico();
    faz_reset();
    troca_por_quantum("single", 32'd99, 0, 32'd99);
  endtask

  task automatic test_reset_meio();
    bit d;
    int vistos;
    faz_reset();
    executa(1'b0, 1'b1, 32'd0, 1'b0, 1'b1, 2'd1, d);
    for (int i = 0; i < Q; i++) executa(1'b1, 1'b1, 32'd8, 1'b0, 1'b0, 2'd0, d);
    avanca(1);
    reset = 1'b1;
    avanca(1);
    reset = 1'b0;
    n_testes++;
    if (processo_atual !== 2'd0 || pc_restaurado !== 32'd0
        || {troca_contexto, congela_pc, parado} !== 3'b000) begin
      n_falhas++;
      $display("FAIL midreset: got proc=%0d pc=%0d flags=%b want 0 0 000",
               processo_atual, pc_restaurado,
               {troca_contexto, congela_pc, parado});
    end
    vistos = 0;
    for (int i = 0; i < 5; i++) begin
      avanca(1);
      if (troca_contexto !== 1'b0 || processo_atual !== 2'd0) vistos++;
    end
    n_testes++;
    if (vistos !== 0) begin
      n_falhas++;
      $display("FAIL midreset_pulse: got %0d bad cycles want 0", vistos);
    end
    for (int i = 0; i < NP; i++) begin
      m_ready[i] = (i == 0);
      m_pc[i] = '0;
    end
    m_cur = 0;
    m_cnt = 0;
  endtask

  task automatic test_aleatorio();
    bit d;
    int lat;
    bit est;
    int nx;
    logic [1:0] id;
    faz_reset();
    for (int it = 0; it < 600; it++) begin
      executa($urandom_range(1, 0) == 1, $urandom_range(7, 0) != 0,
              $urandom, $urandom_range(39, 0) == 0,
              $urandom_range(5, 0) == 0, 2'($urandom_range(3, 0)), d);
      if (!d) begin
        n_testes++;
        if (processo_atual !== 2'(m_cur) || congela_pc !== 1'b0
            || troca_contexto !== 1'b0) begin
          n_falhas++;
          $display("FAIL rnd_run@%0d: got proc=%0d freeze=%b pulse=%b want %0d 0 0",
                   it, processo_atual, congela_pc, troca_contexto, m_cur);
        end
        continue;
      end
      nx = proximo();
      if (nx < 0) begin
        espera_ocioso("rnd");
        id = 2'($urandom_range(NP - 1, 0));
        executa(1'b0, 1'b1, 32'd0, 1'b0, 1'b1, id, d);
        nx = proximo();
      end
      aguarda_pulso(8, lat, est);
      n_testes++;
      if (lat !== 3 || !est || processo_atual !== 2'(nx)
          || pc_restaurado !== m_pc[nx]) begin
        n_falhas++;
        $display("FAIL rnd_switch@%0d: got lat=%0d proc=%0d pc=%h want 3 %0d %h",
                 it, lat, processo_atual, pc_restaurado, nx, m_pc[nx]);
      end
      m_cur = nx;
      m_cnt = 0;
    end
  endtask

  initial begin
    test_reset();
    test_expiracao();
    test_ida_volta();
    test_fim();
    test_sem_preempcao();
    test_processo_unico();
    test_reset_meio();
    test_aleatorio();
    $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
    $finish;
  end

endmodule
